// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared types and width helper for the board matcher
//
// Contents:
//   state_e  : evaluation FSM states
//   dir_e    : edge-search directions, in search order
//   addr_w() : index width for a count of items (never less than 1)

package board_pkg;

  typedef enum logic [3:0] {
    COOL,
    IDLE,
    LOAD,
    CHECK,
    RD0,
    RD1,
    CMP,
    SCAN,
    DONE
  } state_e;

  // Search order matters: SCAN advances UP -> RIGHT -> DOWN -> LEFT.
  typedef enum logic [1:0] {
    UP,
    RIGHT,
    DOWN,
    LEFT
  } dir_e;

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/board_matcher_sel_encoder.sv
// rtl/board_matcher_sel_encoder.sv - popcount and highest/lowest set cell of the selection bus
//
// Purely combinational. Row and column of each result come from loop
// constants, so no divider is built.
//
// Ports:
//   sel_i     : one bit per cell, set = selected
//   count_o   : number of selected cells
//   hi_*_o    : index/row/col of the highest selected cell
//   lo_*_o    : index/row/col of the lowest selected cell

module sel_encoder #(
  parameter int ROWS   = 6,
  parameter int COLS   = 6,
  parameter int N      = ROWS * COLS,
  parameter int ADDR_W = 6,
  parameter int RC_W   = 3,
  parameter int CNT_W  = 6
) (
  input  logic [N-1:0]      sel_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [ADDR_W-1:0] hi_idx_o,
  output logic [RC_W-1:0]   hi_row_o,
  output logic [RC_W-1:0]   hi_col_o,
  output logic [ADDR_W-1:0] lo_idx_o,
  output logic [RC_W-1:0]   lo_row_o,
  output logic [RC_W-1:0]   lo_col_o
);

  // Ascending scan: the last hit is the highest index.
  always_comb begin
    count_o  = '0;
    hi_idx_o = '0;
    hi_row_o = '0;
    hi_col_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i[i]) begin
        count_o  = count_o + CNT_W'(1);
        hi_idx_o = ADDR_W'(i);
        hi_row_o = RC_W'(i / COLS);
        hi_col_o = RC_W'(i % COLS);
      end
    end
  end

  // Descending scan: the last hit is the lowest index.
  always_comb begin
    lo_idx_o = '0;
    lo_row_o = '0;
    lo_col_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel_i[i]) begin
        lo_idx_o = ADDR_W'(i);
        lo_row_o = RC_W'(i / COLS);
        lo_col_o = RC_W'(i % COLS);
      end
    end
  end

endmodule

// File: rtl/board_matcher.sv
// rtl/board_matcher.sv - two-card match evaluator with edge-path search
//
// Optional feature macro: BOARD_MATCHER_DIRECT_EN (direct-line test before
// the edge search when both cards share a row or column).
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   sel_bus    : bit i = cell i selected
//   hidden_bus : bit i = cell i removed
//   color      : board read data, valid the cycle after addr
//   addr       : registered board read address
//   ms / mf    : one-cycle match success / failure pulse
//   en_input   : high while idle and accepting user input

module board_matcher
  import board_pkg::*;
#(
  parameter  int ROWS     = 6,
  parameter  int COLS     = 6,
  parameter  int COLOR_W  = 8,
  parameter  int COOLDOWN = 3,
  localparam int N        = ROWS * COLS,
  localparam int ADDR_W   = addr_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       sel_bus,
  input  logic [N-1:0]       hidden_bus,
  input  logic [COLOR_W-1:0] color,
  output logic [ADDR_W-1:0]  addr,
  output logic               ms,
  output logic               mf,
  output logic               en_input
);

  localparam int RC_W  = addr_w((ROWS > COLS) ? ROWS : COLS);
  localparam int CNT_W = addr_w(N + 1);
  localparam int CD_W  = addr_w(COOLDOWN + 1);

  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_COLS = ADDR_W'(COLS);
  localparam logic [RC_W-1:0]   RC_ONE = RC_W'(1);
  localparam logic [RC_W-1:0]   R_LAST = RC_W'(ROWS - 1);
  localparam logic [RC_W-1:0]   C_LAST = RC_W'(COLS - 1);
  localparam logic [CD_W-1:0]   CD_ONE = CD_W'(1);
  localparam logic [CD_W-1:0]   CD_INI = CD_W'(COOLDOWN);

  // Encoder outputs
  logic [CNT_W-1:0]  sel_cnt;
  logic [ADDR_W-1:0] hi_idx, lo_idx;
  logic [RC_W-1:0]   hi_row, hi_col, lo_row, lo_col;

  sel_encoder #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .N      (N),
    .ADDR_W (ADDR_W),
    .RC_W   (RC_W),
    .CNT_W  (CNT_W)
  ) u_sel_encoder (
    .sel_i    (sel_bus),
    .count_o  (sel_cnt),
    .hi_idx_o (hi_idx),
    .hi_row_o (hi_row),
    .hi_col_o (hi_col),
    .lo_idx_o (lo_idx),
    .lo_row_o (lo_row),
    .lo_col_o (lo_col)
  );

  state_e              state_q, state_d;
  logic [CD_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   c0_idx_q, c0_idx_d, c1_idx_q, c1_idx_d;
  logic [RC_W-1:0]     c0_row_q, c0_row_d, c0_col_q, c0_col_d;
  logic [RC_W-1:0]     c1_row_q, c1_row_d, c1_col_q, c1_col_d;
  logic [N-1:0]        hid_q, hid_d;
  logic [COLOR_W-1:0]  c0_color_q, c0_color_d;
  dir_e                dir_q, dir_d;
  logic [ADDR_W-1:0]   walk_idx_q, walk_idx_d;
  logic [RC_W-1:0]     walk_row_q, walk_row_d, walk_col_q, walk_col_d;
  logic                from_c1_q, from_c1_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ms_q, ms_d, mf_q, mf_d;
`ifdef BOARD_MATCHER_DIRECT_EN
  logic                direct_q, direct_d;
`endif

  // One-cell neighbour of the walker in the current direction.
  logic [ADDR_W-1:0] nxt_idx;
  logic [RC_W-1:0]   nxt_row, nxt_col;
  logic              at_border, nxt_hidden;

  always_comb begin
    nxt_idx   = walk_idx_q;
    nxt_row   = walk_row_q;
    nxt_col   = walk_col_q;
    at_border = 1'b0;
    case (dir_q)
      UP: begin
        at_border = (walk_row_q == '0);
        nxt_idx   = walk_idx_q - A_COLS;
        nxt_row   = walk_row_q - RC_ONE;
      end
      RIGHT: begin
        at_border = (walk_col_q == C_LAST);
        nxt_idx   = walk_idx_q + A_ONE;
        nxt_col   = walk_col_q + RC_ONE;
      end
      DOWN: begin
        at_border = (walk_row_q == R_LAST);
        nxt_idx   = walk_idx_q + A_COLS;
        nxt_row   = walk_row_q + RC_ONE;
      end
      default: begin
        at_border = (walk_col_q == '0);
        nxt_idx   = walk_idx_q - A_ONE;
        nxt_col   = walk_col_q - RC_ONE;
      end
    endcase
    // The neighbour index is off-board when at the border; never look it up.
    nxt_hidden = !at_border && hid_q[nxt_idx];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    c0_idx_d   = c0_idx_q;
    c0_row_d   = c0_row_q;
    c0_col_d   = c0_col_q;
    c1_idx_d   = c1_idx_q;
    c1_row_d   = c1_row_q;
    c1_col_d   = c1_col_q;
    hid_d      = hid_q;
    c0_color_d = c0_color_q;
    dir_d      = dir_q;
    walk_idx_d = walk_idx_q;
    walk_row_d = walk_row_q;
    walk_col_d = walk_col_q;
    from_c1_d  = from_c1_q;
    addr_d     = '0;
    ms_d       = 1'b0;
    mf_d       = 1'b0;
`ifdef BOARD_MATCHER_DIRECT_EN
    direct_d   = direct_q;
`endif

    case (state_q)
      COOL: begin
        if (cnt_q <= CD_ONE) state_d = IDLE;
        else                 cnt_d   = cnt_q - CD_ONE;
      end

      IDLE: begin
        if (sel_cnt == CNT_W'(2)) begin
          state_d  = LOAD;
          c0_idx_d = hi_idx;
          c0_row_d = hi_row;
          c0_col_d = hi_col;
          c1_idx_d = lo_idx;
          c1_row_d = lo_row;
          c1_col_d = lo_col;
        end
      end

      LOAD: begin
        hid_d   = hidden_bus;
        state_d = CHECK;
      end

      CHECK: begin
        if (hid_q[c0_idx_q] || hid_q[c1_idx_q]) begin
          state_d = IDLE;
        end else begin
          state_d = RD0;
          addr_d  = c0_idx_q;
        end
      end

      RD0: begin
        state_d = RD1;
        addr_d  = c1_idx_q;
      end

      RD1: begin
        c0_color_d = color;
        state_d    = CMP;
      end

      // color now carries c1 and is compared directly.
      CMP: begin
        if (c0_color_q != color) begin
          mf_d    = 1'b1;
          state_d = DONE;
        end else begin
          state_d    = SCAN;
          dir_d      = UP;
          walk_idx_d = c0_idx_q;
          walk_row_d = c0_row_q;
          walk_col_d = c0_col_q;
          from_c1_d  = 1'b0;
`ifdef BOARD_MATCHER_DIRECT_EN
          // coord0 is the higher index, so coord1 lies to its left or above.
          if (c0_row_q == c1_row_q) begin
            direct_d = 1'b1;
            dir_d    = LEFT;
          end else if (c0_col_q == c1_col_q) begin
            direct_d = 1'b1;
            dir_d    = UP;
          end
`endif
        end
      end

      SCAN: begin
`ifdef BOARD_MATCHER_DIRECT_EN
        if (direct_q) begin
          if (nxt_idx == c1_idx_q) begin
            ms_d     = 1'b1;
            direct_d = 1'b0;
            state_d  = DONE;
          end else if (nxt_hidden) begin
            walk_idx_d = nxt_idx;
            walk_row_d = nxt_row;
            walk_col_d = nxt_col;
          end else begin
            direct_d   = 1'b0;
            dir_d      = UP;
            walk_idx_d = c0_idx_q;
            walk_row_d = c0_row_q;
            walk_col_d = c0_col_q;
          end
        end else begin
`endif
          if (at_border) begin
            if (!from_c1_q) begin
              walk_idx_d = c1_idx_q;
              walk_row_d = c1_row_q;
              walk_col_d = c1_col_q;
              from_c1_d  = 1'b1;
            end else begin
              ms_d    = 1'b1;
              state_d = DONE;
            end
          end else if (nxt_hidden) begin
            walk_idx_d = nxt_idx;
            walk_row_d = nxt_row;
            walk_col_d = nxt_col;
          end else if (dir_q == LEFT) begin
            mf_d    = 1'b1;
            state_d = DONE;
          end else begin
            dir_d      = dir_e'(dir_q + 2'd1);
            walk_idx_d = c0_idx_q;
            walk_row_d = c0_row_q;
            walk_col_d = c0_col_q;
            from_c1_d  = 1'b0;
          end
`ifdef BOARD_MATCHER_DIRECT_EN
        end
`endif
      end

      DONE: begin
        state_d = COOL;
        cnt_d   = CD_INI;
      end

      default: begin
        state_d = COOL;
        cnt_d   = CD_INI;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COOL;
      cnt_q      <= CD_INI;
      c0_idx_q   <= '0;
      c0_row_q   <= '0;
      c0_col_q   <= '0;
      c1_idx_q   <= '0;
      c1_row_q   <= '0;
      c1_col_q   <= '0;
      hid_q      <= '0;
      c0_color_q <= '0;
      dir_q      <= UP;
      walk_idx_q <= '0;
      walk_row_q <= '0;
      walk_col_q <= '0;
      from_c1_q  <= 1'b0;
      addr_q     <= '0;
      ms_q       <= 1'b0;
      mf_q       <= 1'b0;
`ifdef BOARD_MATCHER_DIRECT_EN
      direct_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      c0_idx_q   <= c0_idx_d;
      c0_row_q   <= c0_row_d;
      c0_col_q   <= c0_col_d;
      c1_idx_q   <= c1_idx_d;
      c1_row_q   <= c1_row_d;
      c1_col_q   <= c1_col_d;
      hid_q      <= hid_d;
      c0_color_q <= c0_color_d;
      dir_q      <= dir_d;
      walk_idx_q <= walk_idx_d;
      walk_row_q <= walk_row_d;
      walk_col_q <= walk_col_d;
      from_c1_q  <= from_c1_d;
      addr_q     <= addr_d;
      ms_q       <= ms_d;
      mf_q       <= mf_d;
`ifdef BOARD_MATCHER_DIRECT_EN
      direct_q   <= direct_d;
`endif
    end
  end

  assign addr     = addr_q;
  assign ms       = ms_q;
  assign mf       = mf_q;
  assign en_input = (state_q == COOL) || (state_q == IDLE);

endmodule

// File: tb/tb_board_matcher.sv
// tb/tb_board_matcher.sv - scoreboard bench for board_matcher on a 6x6 board

module tb_board_matcher;

  localparam int ROWS     = 6;
  localparam int COLS     = 6;
  localparam int COLOR_W  = 8;
  localparam int COOLDOWN = 3;
  localparam int N        = ROWS * COLS;
  localparam int ADDR_W   = 6;
`ifdef BOARD_MATCHER_DIRECT_EN
  localparam int DIRECT   = 1;
`else
  localparam int DIRECT   = 0;
`endif

  localparam int V_NONE = 0;
  localparam int V_MS   = 1;
  localparam int V_MF   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       sel_bus;
  logic [N-1:0]       hidden_bus;
  logic [COLOR_W-1:0] color = '0;
  logic [ADDR_W-1:0]  addr;
  logic               ms, mf, en_input;

  board_matcher #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .COLOR_W  (COLOR_W),
    .COOLDOWN (COOLDOWN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_bus    (sel_bus),
    .hidden_bus (hidden_bus),
    .color      (color),
    .addr       (addr),
    .ms         (ms),
    .mf         (mf),
    .en_input   (en_input)
  );

  always #5 clk = ~clk;

  // Board memory with one cycle of read latency.
  logic [COLOR_W-1:0] mem [0:63];
  always @(posedge clk) color <= mem[addr];

  int    checks = 0;
  int    errors = 0;
  int    exp_q[$];
  int    exp_v;
  string cur_name = "reset";

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every ms/mf pulse must match the next queued verdict.
  always @(negedge clk) begin
    if (ms || mf) begin
      if (exp_q.size() == 0) begin
        check({cur_name, "_unexpected_pulse"}, int'({ms, mf}), 0);
      end else begin
        exp_v = exp_q.pop_front();
        check({cur_name, "_verdict_msmf"}, int'({ms, mf}), (exp_v == V_MS) ? 2 : 1);
        check({cur_name, "_en_during_pulse"}, int'(en_input), 0);
      end
    end
  end

  // Called at a negedge. Drives a two-cell selection, measures en_input high
  // samples before the evaluation starts and low samples while it runs.
  task automatic run_pair(input string name, input int a, input int b,
                          input logic [N-1:0] hid, input int colour_mode,
                          input int verdict, input int exp_wait, input int exp_low);
    int hi_cnt;
    int lo_cnt;
    bit started;
    cur_name = name;
    for (int i = 0; i < 64; i++) mem[i] = COLOR_W'(i * 7 + 1);
    if (colour_mode == 0) begin
      mem[b] = mem[a];
    end else begin
      mem[a] = 8'h12;
      mem[b] = 8'h34;
    end
    if (verdict != V_NONE) exp_q.push_back(verdict);
    hidden_bus = hid;
    sel_bus    = '0;
    sel_bus[a] = 1'b1;
    sel_bus[b] = 1'b1;
    hi_cnt  = 0;
    started = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!en_input) begin
        started = 1'b1;
        break;
      end
      hi_cnt++;
    end
    if (!started) begin
      check({name, "_start_timeout"}, 0, 1);
      sel_bus = '0;
      return;
    end
    if (exp_wait >= 0) check({name, "_idle_cycles"}, hi_cnt, exp_wait);
    lo_cnt = 1;
    while (lo_cnt < 200) begin
      @(negedge clk);
      if (en_input) break;
      lo_cnt++;
    end
    sel_bus = '0;
    check({name, "_busy_cycles"}, lo_cnt, exp_low);
  endtask

  initial begin
    int lo_cnt;
    rst        = 1'b1;
    sel_bus    = '0;
    hidden_bus = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_ms", int'(ms), 0);
    check("reset_mf", int'(mf), 0);
    check("reset_en_input", int'(en_input), 1);
    check("reset_addr", int'(addr), 0);
    rst = 1'b0;

    run_pair("row0_up",     0,  5, '0,        0, V_MS, 3, 8 + DIRECT);
    run_pair("walk_up",    14, 21, 36'd33548, 0, V_MS, 3, 13);
    run_pair("colour_diff",14, 21, '0,        1, V_MF, 3, 6);
    run_pair("adjacent",   14, 15, '0,        0, (DIRECT != 0) ? V_MS : V_MF, 3,
             (DIRECT != 0) ? 7 : 10);
    run_pair("corners",     0, 35, '0,        0, V_MF, 3, 12);
    run_pair("bottom_edge",30, 35, '0,        0, V_MS, 3, 11 + DIRECT);

    cur_name = "three_sel";
    sel_bus = '0;
    sel_bus[0]  = 1'b1;
    sel_bus[5]  = 1'b1;
    sel_bus[14] = 1'b1;
    lo_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (!en_input) lo_cnt++;
    end
    check("three_sel_busy_cycles", lo_cnt, 0);
    sel_bus = '0;

    run_pair("hidden_sel", 14, 21, 36'd16384, 0, V_NONE, 0, 2);

    // Abort an evaluation in its first SCAN cycle.
    cur_name = "reset_mid_scan";
    for (int i = 0; i < 64; i++) mem[i] = COLOR_W'(i * 7 + 1);
    mem[21] = mem[14];
    hidden_bus  = 36'd33548;
    sel_bus     = '0;
    sel_bus[14] = 1'b1;
    sel_bus[21] = 1'b1;
    lo_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!en_input) begin
        lo_cnt = 1;
        break;
      end
    end
    check("mid_scan_started", lo_cnt, 1);
    repeat (5) @(negedge clk);
    rst     = 1'b1;
    sel_bus = '0;
    @(negedge clk);
    check("mid_scan_rst_ms", int'(ms), 0);
    check("mid_scan_rst_mf", int'(mf), 0);
    check("mid_scan_rst_en_input", int'(en_input), 1);
    check("mid_scan_rst_addr", int'(addr), 0);
    rst = 1'b0;

    run_pair("after_reset", 14, 21, 36'd33548, 0, V_MS, 3, 13);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
